// File: rtl/ext_intr_ctrl.sv
// ext_intr_ctrl: memory-mapped external interrupt controller.
//
// Detects rising edges on up to NSRC peripheral interrupt lines and latches
// them as pending. Pending sources that are also enabled raise the registered
// ext_intr request to the core. The trap handler claims the
// lowest-numbered enabled pending source and later completes it through a
// word-addressed bus port. Only one interrupt is in service at a time.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   src_in     peripheral interrupt lines; bit i is source id i+1
//   bus_addr   word offset: 0=PENDING, 1=ENABLE, 2=CLAIM, 3=COMPLETE
//   bus_rd     read strobe (one cycle per access)
//   bus_wr     write strobe (one cycle per access)
//   bus_wdata  write data
//   bus_rdata  read data, valid the cycle after bus_rd, held until next read
//   ext_intr   registered interrupt request to the core
module ext_intr_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_in,
  input  logic [1:0]      bus_addr,
  input  logic            bus_rd,
  input  logic            bus_wr,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata,
  output logic            ext_intr
);

  localparam logic [1:0] ADDR_PENDING  = 2'd0;
  localparam logic [1:0] ADDR_ENABLE   = 2'd1;
  localparam logic [1:0] ADDR_CLAIM    = 2'd2;
  localparam logic [1:0] ADDR_COMPLETE = 2'd3;

  logic [NSRC-1:0] prev_src_reg;
  logic [NSRC-1:0] pending_reg, pending_next;
  logic [NSRC-1:0] enable_reg, enable_next;
  logic            busy_reg, busy_next;
  logic [4:0]      busy_id_reg, busy_id_next;
  logic [31:0]     rdata_reg, rdata_next;
  logic            ext_intr_reg, ext_intr_next;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] masked;
  logic [NSRC-1:0] claim_clr;
  logic [4:0]      claim_id;
  logic            rd_only;
  logic            claim_go;
  logic            complete_ok;

  assign masked  = pending_reg & enable_reg;
  // A simultaneous write wins over a read, so reads only act when alone.
  assign rd_only = bus_rd & ~bus_wr;
  assign claim_go = rd_only && (bus_addr == ADDR_CLAIM) && !busy_reg && (|masked);
  assign complete_ok = bus_wr && (bus_addr == ADDR_COMPLETE) && busy_reg &&
                       (bus_wdata[4:0] == busy_id_reg);

  // Fixed priority: scan downward so the lowest set index is assigned last.
  always_comb begin
    claim_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (masked[i]) claim_id = 5'(i + 1);
    end
  end

  // Per-source edge detect and pending update. A new edge in the same cycle
  // as the claim of that source keeps it pending.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      localparam logic [4:0] SRC_ID = 5'(gi + 1);
      assign rise[gi]         = src_in[gi] & ~prev_src_reg[gi];
      assign claim_clr[gi]    = claim_go & (claim_id == SRC_ID);
      assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~claim_clr[gi]);
    end
  endgenerate

  always_comb begin
    enable_next   = enable_reg;
    busy_next     = busy_reg;
    busy_id_next  = busy_id_reg;
    rdata_next    = rdata_reg;
    ext_intr_next = (|masked) & ~busy_reg;

    if (bus_wr && (bus_addr == ADDR_ENABLE)) enable_next = bus_wdata[NSRC-1:0];

    if (claim_go) begin
      busy_next    = 1'b1;
      busy_id_next = claim_id;
    end else if (complete_ok) begin
      busy_next    = 1'b0;
      busy_id_next = '0;
    end

    if (bus_rd && bus_wr) begin
      rdata_next = '0;
    end else if (bus_rd) begin
      case (bus_addr)
        ADDR_PENDING:  rdata_next = {{(32-NSRC){1'b0}}, pending_reg};
        ADDR_ENABLE:   rdata_next = {{(32-NSRC){1'b0}}, enable_reg};
        ADDR_CLAIM:    rdata_next = claim_go ? {27'd0, claim_id} : 32'd0;
        default:       rdata_next = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_src_reg <= '0;
      pending_reg  <= '0;
      enable_reg   <= '0;
      busy_reg     <= 1'b0;
      busy_id_reg  <= '0;
      rdata_reg    <= '0;
      ext_intr_reg <= 1'b0;
    end else begin
      prev_src_reg <= src_in;
      pending_reg  <= pending_next;
      enable_reg   <= enable_next;
      busy_reg     <= busy_next;
      busy_id_reg  <= busy_id_next;
      rdata_reg    <= rdata_next;
      ext_intr_reg <= ext_intr_next;
    end
  end

  assign bus_rdata = rdata_reg;
  assign ext_intr  = ext_intr_reg;

endmodule

// File: tb/tb_ext_intr_ctrl.sv
// Testbench for ext_intr_ctrl: a table of one-cycle vectors, each giving the
// inputs applied before a clock edge and the outputs expected after it.
module tb_ext_intr_ctrl;

  localparam int NSRC = 8;

  logic            clk;
  logic            reset;
  logic [NSRC-1:0] src_in;
  logic [1:0]      bus_addr;
  logic            bus_rd;
  logic            bus_wr;
  logic [31:0]     bus_wdata;
  logic [31:0]     bus_rdata;
  logic            ext_intr;

  ext_intr_ctrl #(.NSRC(NSRC)) dut (
    .clk       (clk),
    .reset     (reset),
    .src_in    (src_in),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .ext_intr  (ext_intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [7:0]  src;
    logic [1:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_intr;
  } vec_t;

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_EN   = 2'd1;
  localparam logic [1:0] A_CLM  = 2'd2;
  localparam logic [1:0] A_CMP  = 2'd3;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic rst, input logic [7:0] src, input logic [1:0] addr,
                     input logic rd, input logic wr, input logic [31:0] wdata,
                     input logic chk_rd, input logic [31:0] exp_rd, input logic exp_intr);
    vec_t v;
    v.rst = rst; v.src = src; v.addr = addr; v.rd = rd; v.wr = wr; v.wdata = wdata;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_intr = exp_intr;
    vecs.push_back(v);
  endtask

  // Shorthands: idle cycle, read with expected data, write.
  task automatic idle(input logic [7:0] src, input logic ei);
    add(1'b0, src, A_PEND, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, ei);
  endtask
  task automatic rd(input logic [7:0] src, input logic [1:0] a, input logic [31:0] e, input logic ei);
    add(1'b0, src, a, 1'b1, 1'b0, 32'd0, 1'b1, e, ei);
  endtask
  task automatic wr(input logic [7:0] src, input logic [1:0] a, input logic [31:0] d, input logic ei);
    add(1'b0, src, a, 1'b0, 1'b1, d, 1'b0, 32'd0, ei);
  endtask

  initial begin
    reset = 1'b1; src_in = '0; bus_addr = '0; bus_rd = 1'b0; bus_wr = 1'b0; bus_wdata = '0;

    // Reset state
    add(1'b1, 8'h00, A_PEND, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0);
    add(1'b1, 8'h00, A_PEND, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0);
    // Single source: enable 0x04, one-cycle pulse on bit 2, claim id 3
    wr(8'h00, A_EN, 32'h04, 1'b0);
    idle(8'h04, 1'b0);
    rd(8'h00, A_PEND, 32'h04, 1'b1);
    rd(8'h00, A_CLM, 32'd3, 1'b1);
    rd(8'h00, A_PEND, 32'h00, 1'b0);
    // Wrong-id complete ignored, right id clears busy
    wr(8'h00, A_CMP, 32'd2, 1'b0);
    wr(8'h00, A_CMP, 32'd3, 1'b0);
    idle(8'h00, 1'b0);
    // Two sources at once: lowest id wins, the other follows after complete
    wr(8'h00, A_EN, 32'hFF, 1'b0);
    idle(8'h22, 1'b0);
    idle(8'h00, 1'b1);
    rd(8'h00, A_CLM, 32'd2, 1'b1);
    idle(8'h00, 1'b0);
    wr(8'h00, A_CMP, 32'd2, 1'b0);
    idle(8'h00, 1'b1);
    rd(8'h00, A_CLM, 32'd6, 1'b1);
    idle(8'h00, 1'b0);
    wr(8'h00, A_CMP, 32'd6, 1'b0);
    rd(8'h00, A_CLM, 32'd0, 1'b0);
    // Disabled source stays pending but masked; enabling it raises ext_intr
    wr(8'h00, A_EN, 32'h00, 1'b0);
    idle(8'h01, 1'b0);
    rd(8'h00, A_PEND, 32'h01, 1'b0);
    rd(8'h00, A_EN, 32'h00, 1'b0);
    wr(8'h00, A_EN, 32'h01, 1'b0);
    idle(8'h00, 1'b1);
    rd(8'h00, A_CLM, 32'd1, 1'b1);
    wr(8'h00, A_CMP, 32'd1, 1'b0);
    idle(8'h00, 1'b0);
    // Level held 10 cycles plus two more pulses: merged into one pending bit
    wr(8'h00, A_EN, 32'hFF, 1'b0);
    for (int i = 0; i < 10; i++) idle(8'h08, (i != 0));
    for (int i = 0; i < 4; i++) idle((i % 2 == 1) ? 8'h08 : 8'h00, 1'b1);
    rd(8'h00, A_PEND, 32'h08, 1'b1);
    rd(8'h00, A_CLM, 32'd4, 1'b1);
    idle(8'h00, 1'b0);
    wr(8'h00, A_CMP, 32'd4, 1'b0);
    idle(8'h00, 1'b0);
    rd(8'h00, A_CLM, 32'd0, 1'b0);
    // New edge on the source being claimed: the set wins
    idle(8'h04, 1'b0);
    idle(8'h00, 1'b1);
    rd(8'h04, A_CLM, 32'd3, 1'b1);
    rd(8'h00, A_PEND, 32'h04, 1'b0);
    // Read and write together: write executes, rdata forced to 0
    add(1'b0, 8'h00, A_EN, 1'b1, 1'b1, 32'hFF, 1'b1, 32'd0, 1'b0);
    wr(8'h00, A_CMP, 32'd3, 1'b0);
    idle(8'h00, 1'b1);
    // Reset mid-service with src_in[7] held high across release
    rd(8'h00, A_CLM, 32'd3, 1'b1);
    idle(8'h10, 1'b0);
    add(1'b1, 8'h80, A_PEND, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0);
    idle(8'h80, 1'b0);
    rd(8'h80, A_PEND, 32'h80, 1'b0);
    rd(8'h80, A_EN, 32'h00, 1'b0);
    rd(8'h80, A_CLM, 32'd0, 1'b0);

    for (int k = 0; k < vecs.size(); k++) begin
      reset     = vecs[k].rst;
      src_in    = vecs[k].src;
      bus_addr  = vecs[k].addr;
      bus_rd    = vecs[k].rd;
      bus_wr    = vecs[k].wr;
      bus_wdata = vecs[k].wdata;
      @(posedge clk);
      #1;
      n_tests++;
      if (ext_intr !== vecs[k].exp_intr) begin
        n_fail++;
        $display("FAIL vec%0d ext_intr: got %b expected %b", k, ext_intr, vecs[k].exp_intr);
      end else begin
        $display("vec%0d ext_intr=%b ok", k, ext_intr);
      end
      if (vecs[k].chk_rd) begin
        n_tests++;
        if (bus_rdata !== vecs[k].exp_rd) begin
          n_fail++;
          $display("FAIL vec%0d bus_rdata: got 0x%08h expected 0x%08h", k, bus_rdata, vecs[k].exp_rd);
        end else begin
          $display("vec%0d bus_rdata=0x%08h ok", k, bus_rdata);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
